// File: rtl/morse_rx_decoder_if.sv
// Output-side bundle of the Morse receiver: completed frame on valid/ready plus
// the error and overrun strobes seen by the CPU-side register block.
interface morse_rx_decoder_if #(
  parameter int CODE_W = 32
);
  logic [CODE_W-1:0] code_o;
  logic [5:0]        len_o;
  logic              valid_o;
  logic              ready_i;
  logic              err_o;
  logic              overrun_o;

  modport master (
    output code_o, len_o, valid_o, err_o, overrun_o,
    input  ready_i
  );

  modport slave (
    input  code_o, len_o, valid_o, err_o, overrun_o,
    output ready_i
  );
endinterface

// File: rtl/morse_rx_decoder.sv
// Morse line receiver: times marks/spaces in timebase ticks, classifies dots and
// dashes, assembles frames and hands them out on a held valid/ready register.
module morse_rx_decoder #(
  parameter int CODE_W      = 32,
  parameter int CNT_W       = 8,
  parameter int MIN_MARK    = 1,
  parameter int DOT_DASH_TH = 8,
  parameter int MAX_MARK    = 31,
  parameter int GAP_UNITS   = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               serial_i,
  input  logic               tick_i,
  morse_rx_decoder_if.master bus
);

  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] L_MIN     = CNT_W'(MIN_MARK);
  localparam logic [CNT_W-1:0] L_TH      = CNT_W'(DOT_DASH_TH);
  localparam logic [CNT_W-1:0] L_MAX     = CNT_W'(MAX_MARK);
  localparam logic [CNT_W-1:0] L_GAP_M1  = CNT_W'(GAP_UNITS - 1);
  localparam logic [6:0]       L_CODE_W  = 7'(CODE_W);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARK    = 2'd1,
    ST_SPACE   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  logic              r_sync1;
  logic              r_s;
  logic              r_s_d;
  logic [CNT_W-1:0]  r_cnt;
  logic [CODE_W-1:0] r_buf;
  logic [6:0]        r_n;
  state_t            r_state;
  logic [CODE_W-1:0] r_code;
  logic [5:0]        r_len;
  logic              r_valid;
  logic              r_err;
  logic              r_ovr;

  logic              w_rise;
  logic              w_fall;
  logic              w_gap_tick;
  logic              w_dash;
  logic              w_complete;
  logic [CODE_W-1:0] w_bit;

  assign w_rise     = r_s & ~r_s_d;
  assign w_fall     = ~r_s & r_s_d;
  // The tick that would bring the space count up to GAP_UNITS.
  assign w_gap_tick = tick_i & (r_cnt == L_GAP_M1);
  assign w_dash     = (r_cnt > L_TH);
  assign w_bit      = {{(CODE_W-1){1'b0}}, w_dash} << r_n;
  assign w_complete = (r_state == ST_SPACE) & ~w_rise & w_gap_tick;

  // Two-flop synchronizer plus delayed copy for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync1 <= 1'b0;
      r_s     <= 1'b0;
      r_s_d   <= 1'b0;
    end else begin
      r_sync1 <= serial_i;
      r_s     <= r_sync1;
      r_s_d   <= r_s;
    end
  end

  // Duration counter: restarts on every line edge, saturates at full scale.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (w_rise | w_fall) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (tick_i && (r_cnt != L_CNT_MAX)) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // Frame assembly FSM with registered error strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_buf   <= {CODE_W{1'b0}};
      r_n     <= 7'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_rise) begin
            r_state <= ST_MARK;
            r_buf   <= {CODE_W{1'b0}};
            r_n     <= 7'd0;
          end
        end
        ST_MARK: begin
          if (w_fall) begin
            if (r_cnt < L_MIN) begin
              r_state <= (r_n == 7'd0) ? ST_IDLE : ST_SPACE;
            end else if ((r_cnt > L_MAX) || (r_n == L_CODE_W)) begin
              r_state <= ST_DISCARD;
              r_err   <= 1'b1;
            end else begin
              r_buf   <= r_buf | w_bit;
              r_n     <= r_n + 7'd1;
              r_state <= ST_SPACE;
            end
          end else if (r_cnt > L_MAX) begin
            r_state <= ST_DISCARD;
            r_err   <= 1'b1;
          end
        end
        ST_SPACE: begin
          if (w_rise) begin
            r_state <= ST_MARK;
          end else if (w_gap_tick) begin
            r_state <= ST_IDLE;
          end
        end
        ST_DISCARD: begin
          // Counter only reflects low time once the falling edge has passed.
          if (~r_s && ~w_fall && w_gap_tick) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output holding register with valid/ready handshake and overrun strobe.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_code  <= {CODE_W{1'b0}};
      r_len   <= 6'd0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= 1'b0;
      if (w_complete) begin
        if (!r_valid || bus.ready_i) begin
          r_code  <= r_buf;
          r_len   <= 6'(r_n - 7'd1);
          r_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end else if (r_valid && bus.ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.code_o    = r_code;
  assign bus.len_o     = r_len;
  assign bus.valid_o   = r_valid;
  assign bus.err_o     = r_err;
  assign bus.overrun_o = r_ovr;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Self-checking bench for morse_rx_decoder: directed scenarios plus random frames
// compared against a frame-level model built from mark durations.
`timescale 1ns/1ps
module tb_morse_rx_decoder;
  localparam int CODE_W = 32;
  localparam int TP     = 4;
  localparam int TH     = 8;

  logic clk      = 1'b0;
  logic rst_i    = 1'b1;
  logic serial_i = 1'b0;
  logic tick_i   = 1'b0;

  morse_rx_decoder_if #(.CODE_W(CODE_W)) bus();

  morse_rx_decoder #(.CODE_W(CODE_W)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .serial_i (serial_i),
    .tick_i   (tick_i),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;
  int err_seen     = 0;
  int ovr_seen     = 0;
  logic [31:0] acc_code_q[$];
  logic [5:0]  acc_len_q[$];

  // Passive monitor: strobes and accepted frames, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (bus.err_o) err_seen++;
      if (bus.overrun_o) ovr_seen++;
      if (bus.valid_o && bus.ready_i) begin
        acc_code_q.push_back(bus.code_o);
        acc_len_q.push_back(bus.len_o);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One time unit: TP cycles, tick on the first cycle.
  task automatic unit(input logic lvl);
    for (int i = 0; i < TP; i++) begin
      serial_i = lvl;
      tick_i   = (i == 0);
      step();
    end
    tick_i = 1'b0;
  endtask

  task automatic send_mark(input int d);
    repeat (d) unit(1'b1);
  endtask

  task automatic send_low(input int u);
    repeat (u) unit(1'b0);
  endtask

  task automatic send_marks(input int d[$], input int sp);
    for (int i = 0; i < d.size(); i++) begin
      send_mark(d[i]);
      if (i < d.size() - 1) send_low(sp);
    end
  endtask

  task automatic drain();
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; serial_i = 1'b0; tick_i = 1'b0; bus.ready_i = 1'b0;
    repeat (3) step();
    tests_run++; if (bus.code_o !== 32'h0) begin tests_failed++; $display("FAIL reset_code: got %h want 0", bus.code_o); end
    tests_run++; if (bus.len_o !== 6'd0) begin tests_failed++; $display("FAIL reset_len: got %0d want 0", bus.len_o); end
    tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
    tests_run++; if ({bus.err_o, bus.overrun_o} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b want 00", {bus.err_o, bus.overrun_o}); end
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_basic();
    int d[$];
    acc_code_q.delete(); acc_len_q.delete();
    d = {2, 15, 2};
    send_marks(d, 1);
    for (int j = 0; j < 20; j++) begin
      serial_i = 1'b0; tick_i = ((j % TP) == 0);
      step();
      if (j == 15) begin
        tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_latency_early: got %b want 0", bus.valid_o); end
      end
      if (j == 16) begin
        tests_run++; if (bus.valid_o !== 1'b1) begin tests_failed++; $display("FAIL basic_latency: got %b want 1", bus.valid_o); end
      end
    end
    tick_i = 1'b0;
    repeat (5) step();
    tests_run++; if (bus.valid_o !== 1'b1) begin tests_failed++; $display("FAIL basic_hold_valid: got %b want 1", bus.valid_o); end
    tests_run++; if (bus.code_o !== 32'h2) begin tests_failed++; $display("FAIL basic_code: got %h want 00000002", bus.code_o); end
    tests_run++; if (bus.len_o !== 6'd2) begin tests_failed++; $display("FAIL basic_len: got %0d want 2", bus.len_o); end
    drain();
    tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL basic_release: got %b want 0", bus.valid_o); end
    tests_run++; if (acc_code_q.size() !== 1) begin tests_failed++; $display("FAIL basic_accept_count: got %0d want 1", acc_code_q.size()); end
  endtask

  task automatic test_glitch();
    int e0;
    acc_code_q.delete(); acc_len_q.delete();
    e0 = err_seen;
    serial_i = 1'b1; tick_i = 1'b0; step();
    serial_i = 1'b0; step();
    send_low(8);
    tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL glitch_valid: got %b want 0", bus.valid_o); end
    tests_run++; if (err_seen - e0 !== 0) begin tests_failed++; $display("FAIL glitch_err: got %0d want 0", err_seen - e0); end
    send_mark(3); send_low(6);
    tests_run++; if ({bus.valid_o, bus.len_o, bus.code_o} !== {1'b1, 6'd0, 32'h0}) begin tests_failed++; $display("FAIL glitch_after: got v=%b len=%0d code=%h want v=1 len=0 code=0", bus.valid_o, bus.len_o, bus.code_o); end
    drain();
  endtask

  task automatic test_long_mark();
    int e0;
    int d[$];
    e0 = err_seen;
    d = {31, 1};
    send_marks(d, 2); send_low(6);
    tests_run++; if ({bus.valid_o, bus.len_o, bus.code_o} !== {1'b1, 6'd1, 32'h1}) begin tests_failed++; $display("FAIL max_mark_dash: got v=%b len=%0d code=%h want v=1 len=1 code=1", bus.valid_o, bus.len_o, bus.code_o); end
    tests_run++; if (err_seen - e0 !== 0) begin tests_failed++; $display("FAIL max_mark_noerr: got %0d want 0", err_seen - e0); end
    drain();
    send_mark(40);
    tests_run++; if (err_seen - e0 !== 1) begin tests_failed++; $display("FAIL long_mark_err: got %0d want 1", err_seen - e0); end
    send_low(4);
    tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL long_mark_valid: got %b want 0", bus.valid_o); end
    send_mark(12); send_low(6);
    tests_run++; if ({bus.valid_o, bus.len_o, bus.code_o} !== {1'b1, 6'd0, 32'h1}) begin tests_failed++; $display("FAIL long_mark_recover: got v=%b len=%0d code=%h want v=1 len=0 code=1", bus.valid_o, bus.len_o, bus.code_o); end
    tests_run++; if (err_seen - e0 !== 1) begin tests_failed++; $display("FAIL long_mark_err_once: got %0d want 1", err_seen - e0); end
    drain();
  endtask

  task automatic test_overflow();
    int e0;
    e0 = err_seen;
    for (int i = 0; i < 33; i++) begin
      send_mark(2);
      if (i < 32) send_low(1);
    end
    send_low(6);
    tests_run++; if (err_seen - e0 !== 1) begin tests_failed++; $display("FAIL overflow_err: got %0d want 1", err_seen - e0); end
    tests_run++; if (bus.valid_o !== 1'b0) begin tests_failed++; $display("FAIL overflow_valid: got %b want 0", bus.valid_o); end
    for (int i = 0; i < 32; i++) begin
      send_mark(10);
      if (i < 31) send_low(1);
    end
    send_low(6);
    tests_run++; if ({bus.valid_o, bus.len_o, bus.code_o} !== {1'b1, 6'd31, 32'hFFFF_FFFF}) begin tests_failed++; $display("FAIL full_dashes: got v=%b len=%0d code=%h want v=1 len=31 code=ffffffff", bus.valid_o, bus.len_o, bus.code_o); end
    drain();
  endtask

  task automatic test_overrun();
    int o0;
    int da[$];
    int db[$];
    acc_code_q.delete(); acc_len_q.delete();
    bus.ready_i = 1'b0;
    da = {12, 2};
    db = {2, 2, 12};
    o0 = ovr_seen;
    send_marks(da, 1); send_low(6);
    send_marks(db, 1); send_low(6);
    tests_run++; if (ovr_seen - o0 !== 1) begin tests_failed++; $display("FAIL overrun_pulse: got %0d want 1", ovr_seen - o0); end
    tests_run++; if ({bus.valid_o, bus.len_o, bus.code_o} !== {1'b1, 6'd1, 32'h1}) begin tests_failed++; $display("FAIL overrun_hold: got v=%b len=%0d code=%h want v=1 len=1 code=1", bus.valid_o, bus.len_o, bus.code_o); end
    o0 = ovr_seen;
    send_marks(db, 1);
    for (int j = 0; j < 24; j++) begin
      serial_i = 1'b0; tick_i = ((j % TP) == 0); bus.ready_i = (j == 16);
      step();
    end
    tick_i = 1'b0; bus.ready_i = 1'b0;
    tests_run++; if ({bus.valid_o, bus.len_o, bus.code_o} !== {1'b1, 6'd2, 32'h4}) begin tests_failed++; $display("FAIL b2b_load: got v=%b len=%0d code=%h want v=1 len=2 code=4", bus.valid_o, bus.len_o, bus.code_o); end
    tests_run++; if (ovr_seen - o0 !== 0) begin tests_failed++; $display("FAIL b2b_no_overrun: got %0d want 0", ovr_seen - o0); end
    tests_run++; if ((acc_code_q.size() != 1) || (acc_code_q[0] !== 32'h1)) begin tests_failed++; $display("FAIL b2b_accepted_a: got n=%0d want n=1 code=1", acc_code_q.size()); end
    drain();
  endtask

  task automatic test_reset_mid();
    bus.ready_i = 1'b0;
    send_mark(12); send_low(6);
    send_mark(2); send_low(1);
    unit(1'b1); unit(1'b1);
    rst_i = 1'b1; serial_i = 1'b0; tick_i = 1'b0;
    step();
    tests_run++; if ({bus.valid_o, bus.len_o, bus.code_o, bus.err_o, bus.overrun_o} !== 41'd0) begin tests_failed++; $display("FAIL midreset_outputs: got v=%b len=%0d code=%h err=%b ovr=%b want all 0", bus.valid_o, bus.len_o, bus.code_o, bus.err_o, bus.overrun_o); end
    step(); step();
    rst_i = 1'b0;
    step();
    send_mark(2); send_low(6);
    tests_run++; if ({bus.valid_o, bus.len_o, bus.code_o} !== {1'b1, 6'd0, 32'h0}) begin tests_failed++; $display("FAIL midreset_dot: got v=%b len=%0d code=%h want v=1 len=0 code=0", bus.valid_o, bus.len_o, bus.code_o); end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] exp_code_q[$];
    logic [5:0]  exp_len_q[$];
    int e0, exp_err, k, badpos, dur;
    bit bad;
    logic [31:0] code;
    acc_code_q.delete(); acc_len_q.delete();
    e0 = err_seen; exp_err = 0;
    bus.ready_i = 1'b1;
    for (int f = 0; f < 20; f++) begin
      k      = $urandom_range(1, 8);
      bad    = ($urandom_range(0, 9) == 0);
      badpos = $urandom_range(0, k - 1);
      code   = 32'h0;
      for (int i = 0; i < k; i++) begin
        dur = (bad && i == badpos) ? $urandom_range(33, 36) : $urandom_range(1, 20);
        if (dur > TH) code[i] = 1'b1;
        send_mark(dur);
        if (i < k - 1) send_low($urandom_range(1, 3));
      end
      send_low($urandom_range(5, 7));
      if (bad) exp_err++;
      else begin
        exp_code_q.push_back(code);
        exp_len_q.push_back(6'(k - 1));
      end
    end
    bus.ready_i = 1'b0;
    step();
    tests_run++; if (err_seen - e0 !== exp_err) begin tests_failed++; $display("FAIL rand_err_count: got %0d want %0d", err_seen - e0, exp_err); end
    tests_run++; if (acc_code_q.size() !== exp_code_q.size()) begin tests_failed++; $display("FAIL rand_frame_count: got %0d want %0d", acc_code_q.size(), exp_code_q.size()); end
    for (int i = 0; i < exp_code_q.size() && i < acc_code_q.size(); i++) begin
      tests_run++;
      if ((acc_code_q[i] !== exp_code_q[i]) || (acc_len_q[i] !== exp_len_q[i])) begin
        tests_failed++;
        $display("FAIL rand_frame[%0d]: got code=%h len=%0d want code=%h len=%0d", i, acc_code_q[i], acc_len_q[i], exp_code_q[i], exp_len_q[i]);
      end
    end
  endtask

  initial begin
    bus.ready_i = 1'b0;
    test_reset();
    test_basic();
    test_glitch();
    test_long_mark();
    test_overflow();
    test_overrun();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
